// File: rtl/murax_reset_seq.sv
// murax_reset_seq: PLL-lock + debounced GRESET reset sequencer for Murax.
// Optional io_resetCause port/register: define MURAX_RESET_CAUSE_EN.
module murax_reset_seq #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1024,
  parameter int HOLD_CYCLES     = 255,
  parameter int CNT_WIDTH       = 16
) (
  input  logic       io_mainClk,
  input  logic       io_asyncResetn,
  input  logic       io_greset,
  output logic       io_reset,
  output logic       io_ready
`ifdef MURAX_RESET_CAUSE_EN
  ,
  output logic [1:0] io_resetCause
`endif
);

  typedef enum logic [1:0] {
    S_HOLD,
    S_RUN,
    S_ARMED
  } state_t;

  localparam logic [CNT_WIDTH-1:0] DEB_LAST =
    CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] HOLD_LAST =
    CNT_WIDTH'(HOLD_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic [SYNC_STAGES-1:0] arst_sync;
  logic [SYNC_STAGES-1:0] btn_sync;
  logic                   core_en;
  logic                   s;
  logic                   d;
  logic                   d_q;
  logic                   rel;
  logic [CNT_WIDTH-1:0]   deb_cnt;
  logic [CNT_WIDTH-1:0]   deb_inc;
  logic [CNT_WIDTH-1:0]   hold_cnt;
  logic [CNT_WIDTH-1:0]   hold_inc;
  logic [CNT_WIDTH-1:0]   hold_nxt;
  state_t                 state;
  state_t                 state_nxt;

  assign core_en  = arst_sync[SYNC_STAGES-1];
  assign s        = btn_sync[SYNC_STAGES-1];
  assign deb_inc  = (deb_cnt == CNT_MAX) ? deb_cnt
                                         : deb_cnt + CNT_ONE;
  assign hold_inc = (hold_cnt == CNT_MAX) ? hold_cnt
                                          : hold_cnt + CNT_ONE;

  // PLL lock release enters the clock domain through a flop chain
  always_ff @(posedge io_mainClk or negedge io_asyncResetn) begin
    if (!io_asyncResetn)
      arst_sync <= '0;
    else
      arst_sync <= {arst_sync[SYNC_STAGES-2:0], 1'b1};
  end

  // button sync, debounce, and one-cycle pulse on debounced release
  always_ff @(posedge io_mainClk or negedge io_asyncResetn) begin
    if (!io_asyncResetn) begin
      btn_sync <= '0;
      d        <= 1'b0;
      d_q      <= 1'b0;
      rel      <= 1'b0;
      deb_cnt  <= '0;
    end else if (core_en) begin
      btn_sync <= {btn_sync[SYNC_STAGES-2:0], io_greset};
      d_q      <= d;
      rel      <= d_q & ~d;
      if (s == d) begin
        deb_cnt <= '0;
      end else if (deb_inc == DEB_LAST) begin
        d       <= s;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_inc;
      end
    end
  end

  // next state; a release always (re)starts the full hold window
  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    unique case (state)
      S_HOLD: begin
        if (rel) begin
          hold_nxt = '0;
        end else if (hold_cnt == HOLD_LAST) begin
          hold_nxt  = '0;
          state_nxt = d ? S_ARMED : S_RUN;
        end else begin
          hold_nxt = hold_inc;
        end
      end
      S_RUN: begin
        if (rel) begin
          state_nxt = S_HOLD;
          hold_nxt  = '0;
        end else if (d) begin
          state_nxt = S_ARMED;
        end
      end
      S_ARMED: begin
        if (rel) begin
          state_nxt = S_HOLD;
          hold_nxt  = '0;
        end
      end
      default: begin
        state_nxt = S_HOLD;
        hold_nxt  = '0;
      end
    endcase
  end

  // state, hold counter and outputs decoded from the next state
  always_ff @(posedge io_mainClk or negedge io_asyncResetn) begin
    if (!io_asyncResetn) begin
      state    <= S_HOLD;
      hold_cnt <= '0;
      io_reset <= 1'b1;
      io_ready <= 1'b0;
    end else if (core_en) begin
      state    <= state_nxt;
      hold_cnt <= hold_nxt;
      io_reset <= (state_nxt == S_HOLD);
      io_ready <= (state_nxt == S_RUN);
    end
  end

`ifdef MURAX_RESET_CAUSE_EN
  // last reset source: PLL/power on async clear, button on release
  always_ff @(posedge io_mainClk or negedge io_asyncResetn) begin
    if (!io_asyncResetn)
      io_resetCause <= 2'b01;
    else if (core_en && rel)
      io_resetCause <= 2'b10;
  end
`endif

endmodule

// File: tb/tb_murax_reset_seq.sv
// tb_murax_reset_seq: directed bench with a cycle model of the sequencer.
// Two instances: defaults, and a short one (sync 3, debounce 8, hold 20).
module tb_murax_reset_seq;

  localparam int SA = 2;
  localparam int DA = 1024;
  localparam int HA = 255;
  localparam int SB = 3;
  localparam int DB = 8;
  localparam int HB = 20;

  logic clk = 1'b0;
  logic rst_n;
  logic greset;
  logic reset_a, ready_a, reset_b, ready_b;
`ifdef MURAX_RESET_CAUSE_EN
  logic [1:0] cause_a, cause_b;
`endif

  int vectors     = 0;
  int miscompares = 0;
  bit chk_en      = 1'b0;

  always #5 clk = ~clk;

  murax_reset_seq dut_a (
    .io_mainClk    (clk),
    .io_asyncResetn(rst_n),
    .io_greset     (greset),
    .io_reset      (reset_a),
    .io_ready      (ready_a)
`ifdef MURAX_RESET_CAUSE_EN
    ,
    .io_resetCause (cause_a)
`endif
  );

  murax_reset_seq #(
    .SYNC_STAGES    (SB),
    .DEBOUNCE_CYCLES(DB),
    .HOLD_CYCLES    (HB)
  ) dut_b (
    .io_mainClk    (clk),
    .io_asyncResetn(rst_n),
    .io_greset     (greset),
    .io_reset      (reset_b),
    .io_ready      (ready_b)
`ifdef MURAX_RESET_CAUSE_EN
    ,
    .io_resetCause (cause_b)
`endif
  );

  // model: edges since lock, button sample history, debounced level,
  // remaining hold cycles and whether the button is being held in run
  typedef struct {
    int       since;
    bit       g[4];
    bit       d;
    bit       dl;
    bit       rel;
    int       run;
    int       hold_left;
    bit       armed;
    bit [1:0] cause;
  } mdl_t;

  mdl_t ma, mb;

  function automatic mdl_t minit(int hold);
    mdl_t n;
    n.since     = 0;
    for (int i = 0; i < 4; i++) n.g[i] = 1'b0;
    n.d         = 1'b0;
    n.dl        = 1'b0;
    n.rel       = 1'b0;
    n.run       = 0;
    n.hold_left = hold;
    n.armed     = 1'b0;
    n.cause     = 2'b01;
    return n;
  endfunction

  function automatic mdl_t mstep(mdl_t m, bit gin,
                                 int sync, int deb, int hold);
    mdl_t n = m;
    bit   s;
    if (m.since < sync) begin
      n.since = m.since + 1;
      return n;
    end
    s = m.g[sync-1];
    for (int i = 3; i > 0; i--) n.g[i] = m.g[i-1];
    n.g[0] = gin;
    n.rel  = m.dl & ~m.d;
    n.dl   = m.d;
    if (s == m.d) begin
      n.run = 0;
    end else if (m.run + 1 == deb - 1) begin
      n.d   = s;
      n.run = 0;
    end else begin
      n.run = m.run + 1;
    end
    if (m.rel) begin
      n.hold_left = hold;
      n.armed     = 1'b0;
      n.cause     = 2'b10;
    end else if (m.hold_left > 0) begin
      n.hold_left = m.hold_left - 1;
      if (n.hold_left == 0) n.armed = m.d;
    end else if (m.d) begin
      n.armed = 1'b1;
    end
    return n;
  endfunction

  function automatic bit m_reset(mdl_t m);
    return m.hold_left > 0;
  endfunction

  function automatic bit m_ready(mdl_t m);
    return (m.hold_left == 0) && !m.armed;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ma <= minit(HA);
      mb <= minit(HB);
    end else begin
      ma <= mstep(ma, greset, SA, DA, HA);
      mb <= mstep(mb, greset, SB, DB, HB);
    end
  end

  task automatic chk(string name, logic [1:0] act, logic [1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b at %0t",
               name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("a_reset", reset_a, m_reset(ma));
      chk("a_ready", ready_a, m_ready(ma));
      chk("b_reset", reset_b, m_reset(mb));
      chk("b_ready", ready_b, m_ready(mb));
`ifdef MURAX_RESET_CAUSE_EN
      chk("a_cause", cause_a, ma.cause);
      chk("b_cause", cause_b, mb.cause);
`endif
    end
  end

  task automatic adv(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic pin_cause(logic [1:0] exp);
`ifdef MURAX_RESET_CAUSE_EN
    chk("pin_a_cause", cause_a, exp);
    chk("pin_b_cause", cause_b, exp);
`endif
  endtask

  // caller is 2 time units past an edge; the next edge is edge 1
  task automatic power_up(bit b_ready);
    rst_n = 1'b1;
    adv(22);
    chk("pu_b_reset_22", reset_b, 1'b1);
    adv(1);
    chk("pu_b_reset_23", reset_b, 1'b0);
    chk("pu_b_ready_23", ready_b, b_ready);
    adv(233);
    chk("pu_a_reset_256", reset_a, 1'b1);
    chk("pu_a_ready_256", ready_a, 1'b0);
    adv(1);
    chk("pu_a_reset_257", reset_a, 1'b0);
    chk("pu_a_ready_257", ready_a, 1'b1);
    pin_cause(2'b01);
  endtask

  task automatic pll_drop();
    rst_n = 1'b0;
    #1;
    chk("drop_a_reset", reset_a, 1'b1);
    chk("drop_a_ready", ready_a, 1'b0);
    chk("drop_b_reset", reset_b, 1'b1);
    pin_cause(2'b01);
    adv(2);
  endtask

  initial begin
    rst_n  = 1'b1;
    greset = 1'b0;
    #1 rst_n = 1'b0;
    adv(3);
    chk_en = 1'b1;
    chk("rst_a_reset", reset_a, 1'b1);
    chk("rst_a_ready", ready_a, 1'b0);
    chk("rst_b_reset", reset_b, 1'b1);
    chk("rst_b_ready", ready_b, 1'b0);
    pin_cause(2'b01);

    power_up(1'b1);

    // 1000-cycle glitch is below the default debounce window
    greset = 1'b1;
    adv(1000);
    greset = 1'b0;
    adv(1100);
    chk("glitch_a_ready", ready_a, 1'b1);
    chk("glitch_a_reset", reset_a, 1'b0);

    // valid press / release on the default instance
    greset = 1'b1;
    adv(1025);
    chk("press_a_ready_1025", ready_a, 1'b1);
    adv(1);
    chk("press_a_ready_1026", ready_a, 1'b0);
    chk("press_a_reset_1026", reset_a, 1'b0);
    adv(5000 - 1026);
    greset = 1'b0;
    adv(1026);
    chk("rel_a_reset_1026", reset_a, 1'b0);
    adv(1);
    chk("rel_a_reset_1027", reset_a, 1'b1);
    adv(254);
    chk("rel_a_reset_1281", reset_a, 1'b1);
    adv(1);
    chk("rel_a_reset_1282", reset_a, 1'b0);
    chk("rel_a_ready_1282", ready_a, 1'b1);
    pin_cause(2'b10);

    // short instance: second release 14 cycles into hold restarts it
    greset = 1'b1;
    adv(40);
    greset = 1'b0;
    adv(7);
    greset = 1'b1;
    adv(7);
    greset = 1'b0;
    adv(18);
    chk("restart_b_reset_32", reset_b, 1'b1);
    adv(13);
    chk("restart_b_reset_45", reset_b, 1'b1);
    adv(1);
    chk("restart_b_reset_46", reset_b, 1'b0);
    chk("restart_b_ready_46", ready_b, 1'b1);
    chk("restart_a_ready", ready_a, 1'b1);

    // PLL loss in run, then in hold
    pll_drop();
    power_up(1'b1);
    pll_drop();
    rst_n = 1'b1;
    adv(100);
    chk("midhold_a_reset", reset_a, 1'b1);
    pll_drop();
    power_up(1'b1);

    // button held through power-up
    greset = 1'b1;
    pll_drop();
    power_up(1'b0);
    adv(770);
    chk("held_a_ready_1027", ready_a, 1'b1);
    adv(1);
    chk("held_a_ready_1028", ready_a, 1'b0);
    chk("held_a_reset_1028", reset_a, 1'b0);
    greset = 1'b0;
    adv(11);
    chk("held_b_reset_11", reset_b, 1'b0);
    adv(1);
    chk("held_b_reset_12", reset_b, 1'b1);
    adv(19);
    chk("held_b_reset_31", reset_b, 1'b1);
    adv(1);
    chk("held_b_reset_32", reset_b, 1'b0);
    chk("held_b_ready_32", ready_b, 1'b1);
    adv(995);
    chk("held_a_reset_1027", reset_a, 1'b1);
    adv(255);
    chk("held_a_reset_1282", reset_a, 1'b0);
    chk("held_a_ready_1282", ready_a, 1'b1);
    pin_cause(2'b10);

    adv(4);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
